pc_fetch: RTL

Instruction fetch stage of the RV32I core. Owns the program counter and issues one-at-a-time word fetches on a simple req/gnt/rvalid instruction bus. Holds the returned instruction in a single-entry buffer and presents it, with its address, to the IF/ID pipeline register. It honours pipeline hold and redirects on jumps, discarding any stale in-flight response.

---
 rtl/pc_fetch_if.sv | 20 ++
 rtl/pc_fetch.sv | 81 ++++++++
 2 files changed

// File: rtl/pc_fetch_if.sv
// Instruction bus between the fetch stage (master) and instruction memory (slave).
// Handshake: a transfer occurs on a cycle with ibus_req_o & ibus_gnt_i. req may drop before gnt.
// Exactly one ibus_rvalid_i pulse answers each transfer, at the earliest one cycle after gnt.
interface pc_fetch_if;
  logic        ibus_req_o;
  logic [31:0] ibus_addr_o;
  logic        ibus_gnt_i;
  logic        ibus_rvalid_i;
  logic [31:0] ibus_rdata_i;

  modport master (
    output ibus_req_o, ibus_addr_o,
    input  ibus_gnt_i, ibus_rvalid_i, ibus_rdata_i
  );

  modport slave (
    input  ibus_req_o, ibus_addr_o,
    output ibus_gnt_i, ibus_rvalid_i, ibus_rdata_i
  );
endinterface

// File: rtl/pc_fetch.sv
// RV32I instruction fetch stage: owns the PC and issues one outstanding word fetch at a time.
// The fetched word is kept in a single-entry buffer that feeds the IF/ID register.
module pc_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] INST_NOP = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        jump_en_i,
  input  logic [31:0] jump_addr_i,
  input  logic        hold_flag_i,
  pc_fetch_if.master  ibus,
  output logic [31:0] inst_o,
  output logic [31:0] inst_addr_o,
  output logic        inst_valid_o
);

  logic [31:0] pc;
  logic [31:0] fetch_addr;
  logic [31:0] buf_inst;
  logic [31:0] buf_addr;
  logic        outstanding;
  logic        discard;
  logic        buf_valid;
  logic        consume;
  logic        fire;
  logic        resp;
  logic        load;

  assign consume = buf_valid & ~hold_flag_i;
  // Only issue when the buffer will be free by the time the response can arrive.
  assign ibus.ibus_req_o  = ~outstanding & (~buf_valid | consume) & ~jump_en_i;
  assign ibus.ibus_addr_o = pc;
  assign fire = ibus.ibus_req_o & ibus.ibus_gnt_i;
  assign resp = ibus.ibus_rvalid_i & outstanding;
  assign load = resp & ~discard;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc          <= RESET_PC;
      fetch_addr  <= RESET_PC;
      outstanding <= 1'b0;
      discard     <= 1'b0;
      buf_valid   <= 1'b0;
      buf_inst    <= INST_NOP;
      buf_addr    <= 32'h0;
    end else if (jump_en_i) begin
      pc        <= {jump_addr_i[31:2], 2'b00};
      buf_valid <= 1'b0;
      // A response landing in the jump cycle is simply dropped; otherwise mark the pending one stale.
      if (resp) begin
        outstanding <= 1'b0;
        discard     <= 1'b0;
      end else if (outstanding) begin
        discard <= 1'b1;
      end
    end else begin
      if (fire) begin
        outstanding <= 1'b1;
        pc          <= pc + 32'd4;
        fetch_addr  <= pc;
      end
      if (resp) begin
        outstanding <= 1'b0;
        discard     <= 1'b0;
      end
      if (load) begin
        buf_inst  <= ibus.ibus_rdata_i;
        buf_addr  <= fetch_addr;
        buf_valid <= 1'b1;
      end else if (consume) begin
        buf_valid <= 1'b0;
      end
    end
  end

  assign inst_o       = buf_valid ? buf_inst : INST_NOP;
  assign inst_addr_o  = buf_valid ? buf_addr : 32'h0;
  assign inst_valid_o = buf_valid;

endmodule
